// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit frame: FSM state encoding and
// frame-length constants.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Start and stop bits wrap every frame; parity adds one more cycle when enabled.
    localparam int FRAME_OVERHEAD = 2;
    localparam int PARITY_CYCLES  = 1;

    function automatic int frame_len(input int width, input logic par_en);
        return width + FRAME_OVERHEAD + (par_en ? PARITY_CYCLES : 0);
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Shift register and bit counter for the data portion of a UART frame.
// The LSB of the shift register is always the next data bit to put on the line.
module uart_tx_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             shift,
    input  logic             clear,
    input  logic             advance,
    output logic             done,
    output logic             serial
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
        end else if (load) begin
            shreg <= data;
        end else if (shift) begin
            shreg <= {1'b0, shreg[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (advance) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign done   = (cnt == CNT_W'(WIDTH - 1));
    assign serial = shreg[0];

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, data LSB first, optional externally supplied
// parity bit, stop bit. TX_OUT and Busy are registered from the next state.
module uart_tx_frame
    import uart_tx_pkg::*;
#(
    parameter int OP_WIDTH = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [OP_WIDTH-1:0] P_DATA,
    input  logic                Data_Valid,
    input  logic                PAR_EN,
    input  logic                par_bit,
    output logic                PAR_FLAG,
    output logic                TX_OUT,
    output logic                Busy
);

    state_t state;
    state_t next_state;
    logic   accept;
    logic   par_en_q;
    logic   tx_next;
    logic   done;
    logic   serial;

    // A new word is taken only when the line is idle or finishing its stop bit.
    assign accept   = Data_Valid && !RST && ((state == IDLE) || (state == STOP));
    assign PAR_FLAG = accept;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            par_en_q <= 1'b0;
        end else if (accept) begin
            par_en_q <= PAR_EN;
        end
    end

    always_comb begin
        next_state = state;
        tx_next    = 1'b1;
        case (state)
            IDLE:    if (accept) next_state = START;
            START:   next_state = DATA;
            DATA:    if (done) next_state = par_en_q ? PARITY : STOP;
            PARITY:  next_state = STOP;
            STOP:    next_state = accept ? START : IDLE;
            default: next_state = IDLE;
        endcase
        // Line value is chosen for the state being entered so it appears in that state's cycle.
        case (next_state)
            START:   tx_next = 1'b0;
            DATA:    tx_next = serial;
            PARITY:  tx_next = par_bit;
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            TX_OUT <= 1'b1;
            Busy   <= 1'b0;
        end else begin
            TX_OUT <= tx_next;
            Busy   <= (next_state != IDLE);
        end
    end

    uart_tx_serializer #(
        .WIDTH(OP_WIDTH)
    ) u_serializer (
        .clk    (CLK),
        .rst    (RST),
        .load   (accept),
        .data   (P_DATA),
        .shift  (next_state == DATA),
        .clear  (state == START),
        .advance(state == DATA),
        .done   (done),
        .serial (serial)
    );

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: directed frame scenarios plus random
// traffic on an 8-bit and a 5-bit instance, checked against an expected-bit queue.
module tb_uart_tx_frame;

    typedef bit bitq_t[$];

    logic       clk;
    logic       rst;
    logic [7:0] data8;
    logic       dv8;
    logic       pen8;
    logic       par8;
    logic       flag8;
    logic       tx8;
    logic       busy8;
    logic [4:0] data5;
    logic       dv5;
    logic       pen5;
    logic       par5;
    logic       flag5;
    logic       tx5;
    logic       busy5;

    bit          odd_mode;
    bitq_t       q8;
    bitq_t       q5;
    logic [31:0] hist8;
    logic [31:0] hist5;
    int          busy_cnt8;
    int          busy_cnt5;
    int          n_checks;
    int          n_errors;

    uart_tx_frame #(.OP_WIDTH(8)) dut8 (
        .CLK(clk), .RST(rst), .P_DATA(data8), .Data_Valid(dv8), .PAR_EN(pen8),
        .par_bit(par8), .PAR_FLAG(flag8), .TX_OUT(tx8), .Busy(busy8)
    );

    uart_tx_frame #(.OP_WIDTH(5)) dut5 (
        .CLK(clk), .RST(rst), .P_DATA(data5), .Data_Valid(dv5), .PAR_EN(pen5),
        .par_bit(par5), .PAR_FLAG(flag5), .TX_OUT(tx5), .Busy(busy5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered parity stage that captures the word whenever the framer raises PAR_FLAG.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            par8 <= 1'b0;
            par5 <= 1'b0;
        end else begin
            if (flag8) par8 <= odd_mode ? ~^data8 : ^data8;
            if (flag5) par5 <= odd_mode ? ~^data5 : ^data5;
        end
    end

    function automatic bitq_t frameBits(input int w, input logic [8:0] d, input bit pe);
        bitq_t q;
        bit    p;
        p = odd_mode;
        q.push_back(1'b0);
        for (int i = 0; i < w; i++) begin
            q.push_back(d[i]);
            p ^= d[i];
        end
        if (pe) q.push_back(p);
        q.push_back(1'b1);
        return q;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, then advance the model at the edge.
    task automatic applyStimulus(input logic v8, input logic [7:0] d8, input logic e8,
                                 input logic v5, input logic [4:0] d5, input logic e5);
        bit    acc8;
        bit    acc5;
        bitq_t f;
        dv8 = v8; data8 = d8; pen8 = e8;
        dv5 = v5; data5 = d5; pen5 = e5;
        @(negedge clk);
        acc8 = v8 && !rst && (q8.size() <= 1);
        acc5 = v5 && !rst && (q5.size() <= 1);
        checkOutput("tx8", 32'(tx8), (q8.size() != 0) ? 32'(q8[0]) : 32'd1);
        checkOutput("busy8", 32'(busy8), 32'(q8.size() != 0));
        checkOutput("par_flag8", 32'(flag8), 32'(acc8));
        checkOutput("tx5", 32'(tx5), (q5.size() != 0) ? 32'(q5[0]) : 32'd1);
        checkOutput("busy5", 32'(busy5), 32'(q5.size() != 0));
        checkOutput("par_flag5", 32'(flag5), 32'(acc5));
        hist8 = {hist8[30:0], tx8};
        hist5 = {hist5[30:0], tx5};
        if (busy8) busy_cnt8++;
        if (busy5) busy_cnt5++;
        @(posedge clk);
        if (rst) begin
            q8.delete();
            q5.delete();
        end else begin
            if (q8.size() != 0) void'(q8.pop_front());
            if (q5.size() != 0) void'(q5.pop_front());
            if (acc8) begin
                f = frameBits(8, {1'b0, d8}, e8);
                foreach (f[i]) q8.push_back(f[i]);
            end
            if (acc5) begin
                f = frameBits(5, {4'b0, d5}, e5);
                foreach (f[i]) q5.push_back(f[i]);
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 5'h00, 1'b0);
    endtask

    task automatic send8(input logic [7:0] d, input logic pe);
        applyStimulus(1'b1, d, pe, 1'b0, 5'h00, 1'b0);
    endtask

    task automatic send5(input logic [4:0] d, input logic pe);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, d, pe);
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        busy_cnt8 = 0; busy_cnt5 = 0;
        hist8 = '0; hist5 = '0;
        odd_mode = 1'b0;
        rst = 1'b1;
        dv8 = 1'b1; data8 = 8'hFF; pen8 = 1'b1;
        dv5 = 1'b1; data5 = 5'h1F; pen5 = 1'b1;
        #1;
        checkOutput("reset_tx", 32'(tx8), 32'd1);
        checkOutput("reset_busy", 32'(busy8), 32'd0);
        checkOutput("reset_flag", 32'(flag8), 32'd0);
        @(posedge clk);
        #1;
        idle(2);
        rst = 1'b0;

        // 0xA5 without parity, accepted on the first edge after reset release.
        send8(8'hA5, 1'b0);
        idle(10);
        checkOutput("a5_noparity_bits", 32'(hist8[9:0]), 32'(10'b0101001011));
        idle(1);
        checkOutput("a5_busy_after", 32'(busy8), 32'd0);

        // 0xA5 with even then odd parity.
        odd_mode = 1'b0;
        send8(8'hA5, 1'b1);
        idle(11);
        checkOutput("a5_even_bits", 32'(hist8[10:0]), 32'(11'b01010010101));
        idle(1);
        odd_mode = 1'b1;
        send8(8'hA5, 1'b1);
        idle(11);
        checkOutput("a5_odd_bits", 32'(hist8[10:0]), 32'(11'b01010010111));
        idle(1);
        odd_mode = 1'b0;

        // Back-to-back frames: second word offered during the first stop bit.
        busy_cnt8 = 0;
        send8(8'h0F, 1'b0);
        idle(9);
        send8(8'hF0, 1'b0);
        idle(11);
        checkOutput("b2b_busy_cycles", 32'(busy_cnt8), 32'd20);

        // Data_Valid during DATA is ignored.
        send8(8'h55, 1'b0);
        idle(3);
        send8(8'h33, 1'b1);
        idle(9);

        // Reset in the 4th data bit aborts immediately, then 0x81 goes out cleanly.
        send8(8'hC3, 1'b0);
        idle(4);
        rst = 1'b1;
        #1;
        checkOutput("abort_tx", 32'(tx8), 32'd1);
        checkOutput("abort_busy", 32'(busy8), 32'd0);
        q8.delete();
        q5.delete();
        idle(2);
        rst = 1'b0;
        send8(8'h81, 1'b0);
        idle(10);
        checkOutput("after_abort_bits", 32'(hist8[9:0]), 32'(10'b0100000011));
        idle(2);

        // Five-bit instance with parity: 0x1F gives an 8-cycle frame.
        busy_cnt5 = 0;
        send5(5'h1F, 1'b1);
        idle(8);
        checkOutput("w5_bits", 32'(hist5[7:0]), 32'(8'b01111111));
        idle(2);
        checkOutput("w5_busy_cycles", 32'(busy_cnt5), 32'd8);

        // Random traffic on both instances.
        odd_mode = bit'($urandom_range(0, 1));
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) == 0, 8'($urandom), 1'($urandom_range(0, 1)),
                          $urandom_range(0, 3) == 0, 5'($urandom), 1'($urandom_range(0, 1)));
        end
        idle(14);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame.md
UART_TX_FRAME -- requirements
Module: uart_tx_frame

Interface
REQ-001 SHALL have parameter OP_WIDTH, default 8, meaning data bits per frame (legal 5..9).
REQ-002 SHALL have port CLK  input  1  single transmit bit clock; all state on rising edge.
REQ-003 SHALL have port RST  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port P_DATA  input  OP_WIDTH  parallel word to transmit.
REQ-005 SHALL have port Data_Valid  input  1  P_DATA valid this cycle.
REQ-006 SHALL have port PAR_EN  input  1  include a parity bit in the frame.
REQ-007 SHALL have port par_bit  input  1  registered parity bit from the parity stage.
REQ-008 SHALL have port PAR_FLAG  output  1  tells the parity stage to capture P_DATA this cycle.
REQ-009 SHALL have port TX_OUT  output  1  serial line, idle high.
REQ-010 SHALL have port Busy  output  1  frame in progress.

Function
REQ-011 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; one state-cycle per CLK per bit.
REQ-012 SHALL accept a word when Data_Valid=1 and state is IDLE or STOP ("accept" cycle).
REQ-013 SHALL drive PAR_FLAG combinationally = accept condition, so par_bit is valid from the next cycle.
REQ-014 SHALL, at the accept edge, latch P_DATA and PAR_EN, enter START, and ignore both inputs until the next accept.
REQ-015 SHALL ignore Data_Valid in START, DATA and PARITY; no queuing, no error flag.
REQ-016 SHALL register TX_OUT: START drives 0; DATA drives latched bits LSB first, one per cycle; PARITY drives par_bit; STOP and IDLE drive 1.
REQ-017 SHALL use a bit counter of width clog2(OP_WIDTH), cleared on entering DATA; DATA exits when counter = OP_WIDTH-1.
REQ-018 SHALL transition DATA -> PARITY if latched PAR_EN=1, else DATA -> STOP; PARITY -> STOP after one cycle.
REQ-019 SHALL transition STOP -> START on accept (back-to-back, no idle gap), else STOP -> IDLE.
REQ-020 SHALL produce frame length 2+OP_WIDTH cycles without parity, 3+OP_WIDTH with parity.
REQ-021 SHALL assert Busy registered, high from the cycle after accept through the STOP cycle; low in IDLE.
REQ-022 SHALL keep Busy high continuously across back-to-back frames.
REQ-023 SHALL sample par_bit only in PARITY state; par_bit changes elsewhere have no effect on TX_OUT.

Reset
REQ-024 SHALL on RST=1 immediately force state IDLE, TX_OUT=1, Busy=0, PAR_FLAG=0, counter=0, data latch=0.
REQ-025 SHALL abort any frame on reset mid-operation; no partial-frame resume after RST deasserts.
REQ-026 SHALL accept a Data_Valid on the first rising edge after RST deasserts.

Structure
REQ-027 SHALL take state encoding (3-bit, IDLE=0) and the frame-length constants from the shared package uart_tx_pkg.
REQ-028 SHALL split the shift register and bit counter into sub-module uart_tx_serializer (load, shift enable, done, serial bit); FSM and output mux stay in uart_tx_frame.
REQ-029 SHALL contain no parity computation; parity comes only through par_bit.

Verification
REQ-030 SHALL check OP_WIDTH=8, PAR_EN=0, P_DATA=0xA5 pulse -> TX_OUT 0,1,0,1,0,0,1,0,1,1 over 10 cycles, then Busy=0.
REQ-031 SHALL check PAR_EN=1, P_DATA=0xA5, even parity stage -> 11-cycle frame with parity cycle = 0; odd -> 1; PAR_FLAG high exactly on the accept cycle.
REQ-032 SHALL check back-to-back 0x0F then 0xF0 with Data_Valid during first STOP -> second start bit on the next cycle, Busy never drops, 20 cycles total.
REQ-033 SHALL check Data_Valid with 0x33 pulsed during DATA of a 0x55 frame -> ignored; only 0x55 bits appear; PAR_FLAG stays 0.
REQ-034 SHALL check RST=1 asserted in the 4th data bit -> TX_OUT=1 and Busy=0 without waiting for a clock; next frame 0x81 transmits correctly.
REQ-035 SHALL check OP_WIDTH=5, PAR_EN=1, P_DATA=5'h1F -> 8-cycle frame, counter wraps cleanly.
